param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_W, default 32, meaning bits per register entry.
REQ-002 Parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, meaning number of independent read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1, meaning 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset; starts the clear sequence.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  read addresses; port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  read data; port p at bits [p*DATA_W +: DATA_W].
REQ-010 write_enable  input  1  write request for the current cycle.
REQ-011 write_reg  input  ADDR_W  write address.
REQ-012 write_data  input  DATA_W  write data.
REQ-013 busy  output  1  high while the clear sequence runs.
REQ-014 wr_drop  output  1  one-cycle pulse; a write request was discarded.

Function
REQ-015 The FSM SHALL have two states, CLEAR and READY, plus a clear index clr_idx of ADDR_W bits.
REQ-016 rst high at a rising edge SHALL force state CLEAR and clr_idx=0, from either state, with no entry written on that edge.
REQ-017 In CLEAR with rst low, each rising edge SHALL write 0 to entry clr_idx and increment clr_idx.
REQ-018 The edge that clears entry DEPTH-1 SHALL move the state to READY; busy therefore stays high for exactly DEPTH cycles after rst falls.
REQ-019 busy SHALL equal (state==CLEAR) and be registered, not combinational.
REQ-020 In READY, write_enable=1 SHALL write write_data to entry write_reg on the rising edge, except per REQ-021.
REQ-021 When ZERO_REG=1, writes to address 0 SHALL be silently ignored; this is not a drop.
REQ-022 Each read port SHALL be combinational: rd_data[p] = entry[rd_addr[p]], with zero-cycle latency.
REQ-023 A read of address 0 with ZERO_REG=1 SHALL return 0.
REQ-024 In READY, a read with write_enable=1, rd_addr[p]==write_reg, and the write not suppressed by REQ-021 SHALL return write_data in the same cycle (write-through bypass).
REQ-025 In CLEAR, every read port SHALL return 0 regardless of address or array contents.
REQ-026 All read ports SHALL be independent; any ports may read the same address simultaneously.
REQ-027 A write_enable=1 in any cycle where state==CLEAR or rst=1 SHALL be discarded.
REQ-028 wr_drop SHALL be registered high for exactly the cycle after each discarded write.
REQ-029 The register array SHALL have no reset of its own; it is zeroed only by the clear sequence.

Reset
REQ-030 Following any rst edge: state=CLEAR, clr_idx=0, busy=1, wr_drop=0, all rd_data=0.
REQ-031 rst asserted mid-clear SHALL restart the sweep at index 0; the full DEPTH-cycle sweep SHALL follow rst release.
REQ-032 Outputs before the first rst are undefined; the bench SHALL apply rst before checking anything.

Verification (defaults DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1)
REQ-033 rst high 1 cycle, then low -> busy=1 for 32 cycles, busy=0 on cycle 33; afterwards all 32 addresses read 0x00000000.
REQ-034 READY; write x1=0x0000000C, x8=0x0A050102 -> next cycle rd_addr={8,1} yields rd_data={0x0A050102,0x0000000C}.
REQ-035 READY; write_enable=1, write_reg=4, write_data=0xFFFFFFFB, rd_addr0=4 in the same cycle -> rd_data0=0xFFFFFFFB that cycle and after.
REQ-036 READY; write x0=0xDEADBEEF while reading x0 on both ports -> both read 0 that cycle and after; wr_drop stays 0.
REQ-037 During CLEAR, write x5=0xFFFFFFF7 -> wr_drop=1 next cycle only; after busy falls, x5 reads 0.
REQ-038 rst reasserted when clr_idx=10 -> busy stays 1; after rst release, busy falls exactly 32 cycles later; all entries read 0.

Source files
------------

// File: rtl/param_register_file_if.sv
// -----------------------------------------------------------------------------
// param_register_file_if
// Bundles the read ports, the write port and the status flags of
// param_register_file. clk and rst stay plain ports on the module.
//
//   rd_addr      NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data      NUM_RD*DATA_W  read data,      port p at [p*DATA_W +: DATA_W]
//   write_enable 1              write request for the current cycle
//   write_reg    ADDR_W         write address
//   write_data   DATA_W         write data
//   busy         1              high while the clear sweep runs
//   wr_drop      1              one-cycle pulse, a write request was discarded
//
// The master modport is the user of the register file.
// The slave modport is the register file itself.
// -----------------------------------------------------------------------------
interface param_register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) ();
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     write_enable;
   logic [ADDR_W-1:0]        write_reg;
   logic [DATA_W-1:0]        write_data;
   logic                     busy;
   logic                     wr_drop;

   modport master (
      output rd_addr, write_enable, write_reg, write_data,
      input  rd_data, busy, wr_drop
   );

   modport slave (
      input  rd_addr, write_enable, write_reg, write_data,
      output rd_data, busy, wr_drop
   );
endinterface

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// Multi-read-port, single-write-port register file with a hardware clear
// sweep. After rst falls the array is zeroed one entry per cycle (CLEAR).
// Normal reads and writes are only served once the sweep has finished (READY).
//
// Ports
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset, restarts the clear sweep
//   bus  param_register_file_if.slave (read ports, write port, busy, wr_drop)
//
// Notes
//   - Reads are combinational. A committed write in the same cycle is
//     forwarded to any port that reads the write address.
//   - With ZERO_REG=1, entry 0 always reads 0. Writes to it are ignored
//     silently, and such a write does not raise wr_drop.
//   - A write request made during CLEAR or while rst is high is discarded.
//     A discarded write outside reset raises wr_drop for the next cycle.
//     The reset edge itself clears wr_drop.
//   - The array has no reset of its own. Only the sweep clears it.
// -----------------------------------------------------------------------------
module param_register_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   param_register_file_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
   logic                busy_q, busy_d;
   logic                wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                clr_wr_s;
   logic                wr_commit_s;
   logic [NUM_RD*DATA_W-1:0] rd_data_s;

   // Decide whether the sweep or the user port writes the array this cycle.
   always_comb begin
      clr_wr_s    = 1'b0;
      wr_commit_s = 1'b0;
      if (rst) begin
         clr_wr_s    = 1'b0;
         wr_commit_s = 1'b0;
      end else if (state_q == CLEAR) begin
         clr_wr_s    = 1'b1;
         wr_commit_s = 1'b0;
      end else if (bus.write_enable && !((ZERO_REG != 0) && (bus.write_reg == '0))) begin
         clr_wr_s    = 1'b0;
         wr_commit_s = 1'b1;
      end else begin
         clr_wr_s    = 1'b0;
         wr_commit_s = 1'b0;
      end
   end

   // Next-state logic for the CLEAR/READY FSM, the sweep index and the flags.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      wr_drop_d = 1'b0;
      if (rst) begin
         state_d   = CLEAR;
         clr_idx_d = '0;
         wr_drop_d = 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_idx_d = clr_idx_q + ADDR_W'(1);
               // Any write request made during the sweep is lost.
               wr_drop_d = bus.write_enable;
               if (clr_idx_q == {ADDR_W{1'b1}}) begin
                  state_d = READY;
               end else begin
                  state_d = CLEAR;
               end
            end
            READY: begin
               state_d   = READY;
               wr_drop_d = 1'b0;
            end
            default: begin
               state_d   = CLEAR;
               clr_idx_d = '0;
               wr_drop_d = 1'b0;
            end
         endcase
      end
      // busy is a register that tracks the next state, so it equals
      // (state_q == CLEAR) without any combinational path to the output.
      busy_d = (state_d == CLEAR);
   end

   // State register and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         busy_q    <= 1'b1;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         busy_q    <= busy_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Register array. It has no reset and is zeroed only by the sweep.
   always_ff @(posedge clk) begin
      if (clr_wr_s) begin
         mem_q[clr_idx_q] <= '0;
      end else if (wr_commit_s) begin
         mem_q[bus.write_reg] <= bus.write_data;
      end
   end

   // Combinational read ports. Order: clear mask, entry 0, bypass, array.
   always_comb begin
      rd_data_s = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (state_q != READY) begin
            rd_data_s[p*DATA_W +: DATA_W] = '0;
         end else if ((ZERO_REG != 0) && (bus.rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
            rd_data_s[p*DATA_W +: DATA_W] = '0;
         end else if (wr_commit_s && (bus.rd_addr[p*ADDR_W +: ADDR_W] == bus.write_reg)) begin
            rd_data_s[p*DATA_W +: DATA_W] = bus.write_data;
         end else begin
            rd_data_s[p*DATA_W +: DATA_W] = mem_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
         end
      end
   end

   assign bus.rd_data = rd_data_s;
   assign bus.busy    = busy_q;
   assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
// Directed bench for param_register_file with the default parameters
// (DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1). Expected values are
// worked out by hand in the stimulus below.
// -----------------------------------------------------------------------------
module tb_param_register_file;

   logic clk;
   logic rst;
   int   checks_cnt;
   int   fail_cnt;
   int   n_cyc;

   param_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_if ();

   param_register_file #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if it does not match.
   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Waits for the next rising edge, then moves 1 unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sets both read addresses and lets the combinational reads settle.
   task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
      bus_if.rd_addr = {a1, a0};
      #1;
   endtask

   // Writes one entry in READY and then drops write_enable.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus_if.write_enable = 1'b1;
      bus_if.write_reg    = a;
      bus_if.write_data   = d;
      tick();
      bus_if.write_enable = 1'b0;
   endtask

   // Counts rising edges until busy falls. The loop gives up after 100 edges.
   task automatic wait_ready(output int n);
      n = 0;
      while (bus_if.busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   // Checks that every address reads zero, using both ports.
   task automatic sweep_zero(input string tag);
      for (int a = 0; a < 32; a += 2) begin
         rd2(5'(a), 5'(a + 1));
         chk_eq(tag, bus_if.rd_data[31:0], 32'h0000_0000);
         chk_eq(tag, bus_if.rd_data[63:32], 32'h0000_0000);
      end
   endtask

   // Holds rst high for exactly one rising edge.
   task automatic rst_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Directed stimulus, in order of the features under test.
   initial begin
      checks_cnt = 0;
      fail_cnt   = 0;
      rst                 = 1'b0;
      bus_if.write_enable = 1'b0;
      bus_if.write_reg    = 5'd0;
      bus_if.write_data   = 32'h0000_0000;
      bus_if.rd_addr      = 10'd0;
      #2;

      // Reset state and clear length of 32 cycles.
      rst = 1'b1;
      tick();
      rd2(5'd3, 5'd7);
      chk_eq("rst_busy", {31'd0, bus_if.busy}, 32'd1);
      chk_eq("rst_drop", {31'd0, bus_if.wr_drop}, 32'd0);
      chk_eq("rst_rd0", bus_if.rd_data[31:0], 32'h0000_0000);
      chk_eq("rst_rd1", bus_if.rd_data[63:32], 32'h0000_0000);
      rst = 1'b0;
      wait_ready(n_cyc);
      chk_eq("clr_len_a", 32'(n_cyc), 32'd32);
      sweep_zero("sweep_a");

      // Two writes, then both ports read back in one cycle.
      wr(5'd1, 32'h0000_000C);
      wr(5'd8, 32'h0A05_0102);
      rd2(5'd1, 5'd8);
      chk_eq("rd_x1", bus_if.rd_data[31:0], 32'h0000_000C);
      chk_eq("rd_x8", bus_if.rd_data[63:32], 32'h0A05_0102);
      rd2(5'd8, 5'd8);
      chk_eq("same_addr0", bus_if.rd_data[31:0], 32'h0A05_0102);
      chk_eq("same_addr1", bus_if.rd_data[63:32], 32'h0A05_0102);

      // Write-through bypass in the same cycle, and the value stays afterwards.
      bus_if.write_enable = 1'b1;
      bus_if.write_reg    = 5'd4;
      bus_if.write_data   = 32'hFFFF_FFFB;
      rd2(5'd4, 5'd1);
      chk_eq("bypass", bus_if.rd_data[31:0], 32'hFFFF_FFFB);
      chk_eq("bypass_other", bus_if.rd_data[63:32], 32'h0000_000C);
      tick();
      bus_if.write_enable = 1'b0;
      #1;
      chk_eq("bypass_after", bus_if.rd_data[31:0], 32'hFFFF_FFFB);

      // A write to x0 is ignored and is not counted as a drop.
      bus_if.write_enable = 1'b1;
      bus_if.write_reg    = 5'd0;
      bus_if.write_data   = 32'hDEAD_BEEF;
      rd2(5'd0, 5'd0);
      chk_eq("x0_same0", bus_if.rd_data[31:0], 32'h0000_0000);
      chk_eq("x0_same1", bus_if.rd_data[63:32], 32'h0000_0000);
      tick();
      bus_if.write_enable = 1'b0;
      #1;
      chk_eq("x0_after0", bus_if.rd_data[31:0], 32'h0000_0000);
      chk_eq("x0_after1", bus_if.rd_data[63:32], 32'h0000_0000);
      chk_eq("x0_nodrop", {31'd0, bus_if.wr_drop}, 32'd0);

      // Give x5 a nonzero value before the next clear.
      wr(5'd5, 32'h1234_5678);
      rd2(5'd5, 5'd0);
      chk_eq("x5_pre", bus_if.rd_data[31:0], 32'h1234_5678);

      // A write during CLEAR is dropped and wr_drop pulses for one cycle.
      rst_pulse();
      tick();
      tick();
      bus_if.write_enable = 1'b1;
      bus_if.write_reg    = 5'd5;
      bus_if.write_data   = 32'hFFFF_FFF7;
      rd2(5'd5, 5'd8);
      chk_eq("clr_rd_mask0", bus_if.rd_data[31:0], 32'h0000_0000);
      chk_eq("clr_rd_mask1", bus_if.rd_data[63:32], 32'h0000_0000);
      tick();
      bus_if.write_enable = 1'b0;
      chk_eq("drop_pulse", {31'd0, bus_if.wr_drop}, 32'd1);
      tick();
      chk_eq("drop_end", {31'd0, bus_if.wr_drop}, 32'd0);
      wait_ready(n_cyc);
      // Four sweep edges have already passed, so 28 remain.
      chk_eq("clr_len_e", 32'(n_cyc), 32'd28);
      rd2(5'd5, 5'd4);
      chk_eq("x5_cleared", bus_if.rd_data[31:0], 32'h0000_0000);
      chk_eq("x4_cleared", bus_if.rd_data[63:32], 32'h0000_0000);

      // rst mid-sweep at clr_idx=10 restarts the full sweep.
      wr(5'd10, 32'h0000_0055);
      wr(5'd31, 32'hA5A5_A5A5);
      rd2(5'd10, 5'd31);
      chk_eq("x10_pre", bus_if.rd_data[31:0], 32'h0000_0055);
      chk_eq("x31_pre", bus_if.rd_data[63:32], 32'hA5A5_A5A5);
      rst_pulse();
      for (int i = 0; i < 10; i++) tick();
      chk_eq("mid_busy", {31'd0, bus_if.busy}, 32'd1);
      rst_pulse();
      chk_eq("rerst_busy", {31'd0, bus_if.busy}, 32'd1);
      wait_ready(n_cyc);
      chk_eq("clr_len_f", 32'(n_cyc), 32'd32);
      sweep_zero("sweep_f");

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
